// File: rtl/apb_cmd_pkg.sv
// rtl/apb_cmd_pkg.sv - shared definitions for the APB command queue
// Contents: FSM state encoding, default APB widths, command-entry layout helper.
package apb_cmd_pkg;

  localparam int APB_ADDR_WIDTH_DEF = 10;
  localparam int APB_DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } cmd_state_e;

  // Command entry layout, MSB to LSB: {wr_rd, addr[aw-1:0], wdata[dw-1:0]}.
  // wdata sits at bit 0, addr directly above it, wr_rd is the top bit.
  function automatic int cmd_entry_width(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - circular command storage with read/write pointers
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write one entry at the tail
//   pop               drop the head entry (caller guarantees level != 0)
//   head_data         entry at the head, valid while level != 0
//   level             occupancy, 0..DEPTH
module apb_cmd_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/apb_cmd_queue.sv
// rtl/apb_cmd_queue.sv - queued host commands issued one at a time to an APB master
// Ports:
//   apb_clk, apb_reset                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_wr_rd/cmd_addr/cmd_wdata   host command push
//   apb_req/apb_wr_rd/apb_addr/apb_wdata        transfer start pulse and held fields
//   apb_done/apb_rdata/apb_slverr               transfer completion from downstream
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout  host response
//   q_level                                     queued command count
module apb_cmd_queue
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = APB_DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    apb_clk,
  input  logic                    apb_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic                    apb_req,
  output logic                    apb_wr_rd,
  output logic [ADDR_WIDTH-1:0]   apb_addr,
  output logic [DATA_WIDTH-1:0]   apb_wdata,
  input  logic                    apb_done,
  input  logic [DATA_WIDTH-1:0]   apb_rdata,
  input  logic                    apb_slverr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [$clog2(DEPTH):0]  q_level
);

  localparam int ENTRY_W = cmd_entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int TO_W    = $clog2(TIMEOUT + 1);

  cmd_state_e            state_q, state_d;
  logic                  rdy_en_q, rdy_en_d;
  logic                  apb_wr_rd_q, apb_wr_rd_d;
  logic [ADDR_WIDTH-1:0] apb_addr_q, apb_addr_d;
  logic [DATA_WIDTH-1:0] apb_wdata_q, apb_wdata_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [LVL_W-1:0]      fifo_level;

  // rdy_en_q holds cmd_ready low until the first edge after reset release.
  assign cmd_ready = rdy_en_q && (fifo_level != LVL_W'(DEPTH));
  assign fifo_push = cmd_valid && cmd_ready;

  apb_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (apb_clk),
    .rst       (apb_reset),
    .push      (fifo_push),
    .push_data ({cmd_wr_rd, cmd_addr, cmd_wdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .level     (fifo_level)
  );

  always_comb begin
    state_d       = state_q;
    rdy_en_d      = 1'b1;
    fifo_pop      = 1'b0;
    apb_wr_rd_d   = apb_wr_rd_q;
    apb_addr_d    = apb_addr_q;
    apb_wdata_d   = apb_wdata_q;
    to_cnt_d      = to_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (fifo_level != '0) begin
          fifo_pop    = 1'b1;
          apb_wr_rd_d = fifo_head[ENTRY_W-1];
          apb_addr_d  = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
          apb_wdata_d = fifo_head[DATA_WIDTH-1:0];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the last allowed cycle wins over the timeout.
        if (apb_done) begin
          rsp_rdata_d   = (!apb_wr_rd_q && !apb_slverr) ? apb_rdata : '0;
          rsp_err_d     = apb_slverr;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge apb_clk or posedge apb_reset) begin
    if (apb_reset) begin
      state_q       <= ST_IDLE;
      rdy_en_q      <= 1'b0;
      apb_wr_rd_q   <= 1'b0;
      apb_addr_q    <= '0;
      apb_wdata_q   <= '0;
      to_cnt_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdy_en_q      <= rdy_en_d;
      apb_wr_rd_q   <= apb_wr_rd_d;
      apb_addr_q    <= apb_addr_d;
      apb_wdata_q   <= apb_wdata_d;
      to_cnt_q      <= to_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign apb_req     = (state_q == ST_ISSUE);
  assign apb_wr_rd   = apb_wr_rd_q;
  assign apb_addr    = apb_addr_q;
  assign apb_wdata   = apb_wdata_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign q_level     = fifo_level;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// tb/tb_apb_cmd_queue.sv - self-checking bench for apb_cmd_queue
module tb_apb_cmd_queue;

  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  // k: cycles after the apb_req cycle at which the slave raises apb_done
  typedef struct packed {
    logic [7:0]    k;
    logic          err;
    logic [DW-1:0] rdata;
  } plan_t;

  logic                 apb_clk = 1'b0;
  logic                 apb_reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr_rd;
  logic [AW-1:0]        cmd_addr;
  logic [DW-1:0]        cmd_wdata;
  logic                 apb_req;
  logic                 apb_wr_rd;
  logic [AW-1:0]        apb_addr;
  logic [DW-1:0]        apb_wdata;
  logic                 apb_done;
  logic [DW-1:0]        apb_rdata;
  logic                 apb_slverr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  logic [$clog2(DEPTH):0] q_level;

  apb_cmd_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .apb_clk     (apb_clk),
    .apb_reset   (apb_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wr_rd   (cmd_wr_rd),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .apb_req     (apb_req),
    .apb_wr_rd   (apb_wr_rd),
    .apb_addr    (apb_addr),
    .apb_wdata   (apb_wdata),
    .apb_done    (apb_done),
    .apb_rdata   (apb_rdata),
    .apb_slverr  (apb_slverr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .q_level     (q_level)
  );

  always #5 apb_clk = ~apb_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  cmd_t    tx_q[$];      // host commands not yet accepted
  cmd_t    exp_cmds[$];  // accepted commands not yet issued
  plan_t   plan_q[$];    // directed slave behaviour, consumed per transfer
  cmd_t    cur;          // transfer in flight / last issued
  plan_t   cur_plan;
  logic    busy;         // between apb_req and response handshake
  logic    rdy_ok;       // an edge has passed since reset release
  int      cyc;
  int      req_cyc;
  int      exp_lat;
  int      probe_cyc;
  int      n_rsp;
  logic    exp_err, exp_to;
  logic [DW-1:0] exp_rdata;
  int      rr_mode;      // 0: rsp_ready low, 1: high, 2: random
  logic    gap_en, stray_en;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.wr    = 1'($urandom_range(0, 1));
    c.addr  = AW'($urandom);
    c.wdata = DW'($urandom);
    return c;
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    p.k     = 8'($urandom_range(1, TIMEOUT + 3));
    p.err   = ($urandom_range(0, 3) == 0);
    p.rdata = DW'($urandom);
    return p;
  endfunction

  task automatic model_clear();
    tx_q.delete();
    exp_cmds.delete();
    plan_q.delete();
    cur       = '0;
    cur_plan  = '0;
    busy      = 1'b0;
    rdy_ok    = 1'b0;
    probe_cyc = -1;
  endtask

  task automatic monitor();
    logic exp_valid;
    if (apb_req) begin
      check_eq("one_outstanding", 64'(busy), 64'(0));
      if (exp_cmds.size() == 0) begin
        check_eq("req_without_cmd", 64'(0), 64'(1));
      end else begin
        cur      = exp_cmds.pop_front();
        busy     = 1'b1;
        req_cyc  = cyc;
        cur_plan = (plan_q.size() != 0) ? plan_q.pop_front() : rand_plan();
        exp_to   = (int'(cur_plan.k) > TIMEOUT);
        exp_err  = exp_to ? 1'b1 : cur_plan.err;
        exp_rdata = (exp_to || cur_plan.err || cur.wr) ? '0 : cur_plan.rdata;
        exp_lat  = exp_to ? TIMEOUT + 1 : int'(cur_plan.k) + 1;
        if (probe_cyc >= 0) begin
          check_eq("req_latency", 64'(cyc - probe_cyc), 64'(2));
          probe_cyc = -1;
        end
      end
    end
    check_eq("apb_wr_rd", 64'(apb_wr_rd), 64'(cur.wr));
    check_eq("apb_addr",  64'(apb_addr),  64'(cur.addr));
    check_eq("apb_wdata", 64'(apb_wdata), 64'(cur.wdata));
    check_eq("q_level",   64'(q_level),   64'(exp_cmds.size()));
    check_eq("cmd_ready", 64'(cmd_ready), 64'(rdy_ok && (exp_cmds.size() != DEPTH)));
    exp_valid = busy && ((cyc - req_cyc) >= exp_lat);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    if (rsp_valid && exp_valid) begin
      check_eq("rsp_rdata",   64'(rsp_rdata),   64'(exp_rdata));
      check_eq("rsp_err",     64'(rsp_err),     64'(exp_err));
      check_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    end
  endtask

  task automatic drive();
    if (tx_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
      cmd_valid = 1'b1;
      cmd_wr_rd = tx_q[0].wr;
      cmd_addr  = tx_q[0].addr;
      cmd_wdata = tx_q[0].wdata;
    end else begin
      cmd_valid = 1'b0;
      cmd_wr_rd = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
    end
    rsp_ready = (rr_mode == 2) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
    if (busy && cyc == req_cyc + int'(cur_plan.k)) begin
      apb_done   = 1'b1;
      apb_slverr = cur_plan.err;
      apb_rdata  = cur_plan.rdata;
    end else begin
      apb_done   = !busy && stray_en && ($urandom_range(0, 5) == 0);
      apb_slverr = 1'($urandom_range(0, 1));
      apb_rdata  = DW'($urandom);
    end
  endtask

  task automatic step();
    monitor();
    drive();
    if (cmd_valid && cmd_ready) begin
      if (exp_cmds.size() == 0 && !busy) probe_cyc = cyc;
      exp_cmds.push_back(tx_q.pop_front());
    end
    if (rsp_valid && rsp_ready) begin
      busy = 1'b0;
      n_rsp++;
    end
    @(negedge apb_clk);
    cyc++;
    rdy_ok = 1'b1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 3000 && !(tx_q.size() == 0 && exp_cmds.size() == 0 && !busy)) begin
      step();
      i++;
    end
    check_eq("drain_done", 64'(tx_q.size() == 0 && exp_cmds.size() == 0 && !busy), 64'(1));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_cmd_ready"},   64'(cmd_ready),   64'(0));
    check_eq({tag, "_apb_req"},     64'(apb_req),     64'(0));
    check_eq({tag, "_apb_fields"},  64'({apb_wr_rd, apb_addr, apb_wdata}), 64'(0));
    check_eq({tag, "_rsp_valid"},   64'(rsp_valid),   64'(0));
    check_eq({tag, "_rsp_fields"},  64'({rsp_err, rsp_timeout, rsp_rdata}), 64'(0));
    check_eq({tag, "_q_level"},     64'(q_level),     64'(0));
  endtask

  task automatic do_reset();
    #2;
    apb_reset = 1'b1;
    cmd_valid = 1'b0;
    apb_done  = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge apb_clk);
    check_zero("rst_hold");
    apb_reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int base;
    int i;
    apb_reset  = 1'b1;
    cmd_valid  = 1'b0;
    cmd_wr_rd  = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    apb_done   = 1'b0;
    apb_rdata  = '0;
    apb_slverr = 1'b0;
    rsp_ready  = 1'b0;
    cyc = 0; req_cyc = 0; exp_lat = 0; n_rsp = 0;
    exp_err = 1'b0; exp_to = 1'b0; exp_rdata = '0;
    rr_mode = 1; gap_en = 1'b0; stray_en = 1'b0;
    model_clear();
    repeat (2) @(negedge apb_clk);
    check_zero("reset");
    apb_reset = 1'b0;

    // Write then read back through the same address
    base = n_rsp;
    tx_q.push_back('{wr: 1'b1, addr: 10'h004, wdata: 32'hDEADBEEF});
    tx_q.push_back('{wr: 1'b0, addr: 10'h004, wdata: 32'h0});
    plan_q.push_back('{k: 8'd3, err: 1'b0, rdata: 32'hDEADBEEF});
    plan_q.push_back('{k: 8'd3, err: 1'b0, rdata: 32'hDEADBEEF});
    drain();
    check_eq("wr_rd_count", 64'(n_rsp - base), 64'(2));

    // Slave error on a read of the top address
    tx_q.push_back('{wr: 1'b0, addr: 10'h3FF, wdata: 32'h0});
    plan_q.push_back('{k: 8'd2, err: 1'b1, rdata: 32'h12345678});
    drain();

    // Timeout, with a stray apb_done arriving while the response is held
    rr_mode = 0;
    tx_q.push_back(rand_cmd());
    plan_q.push_back('{k: 8'(TIMEOUT + 2), err: 1'b0, rdata: 32'hA5A5A5A5});
    repeat (TIMEOUT + 8) step();
    check_eq("to_rsp_valid",   64'(rsp_valid),   64'(1));
    check_eq("to_rsp_timeout", 64'(rsp_timeout), 64'(1));
    rr_mode = 1;
    drain();

    // Full queue under response backpressure
    rr_mode = 0;
    base = n_rsp;
    for (int j = 0; j < 6; j++) begin
      tx_q.push_back(rand_cmd());
      plan_q.push_back('{k: 8'd2, err: 1'b0, rdata: DW'($urandom)});
    end
    repeat (20) step();
    check_eq("full_q_level",   64'(q_level),     64'(DEPTH));
    check_eq("full_cmd_ready", 64'(cmd_ready),   64'(0));
    check_eq("full_rsp_valid", 64'(rsp_valid),   64'(1));
    check_eq("full_stalled",   64'(tx_q.size()), 64'(1));
    rr_mode = 1;
    drain();
    check_eq("full_count", 64'(n_rsp - base), 64'(6));

    // Reset while waiting, with three commands queued behind
    base = n_rsp;
    for (int j = 0; j < 4; j++) tx_q.push_back(rand_cmd());
    plan_q.push_back('{k: 8'd200, err: 1'b0, rdata: 32'h0});
    i = 0;
    while (i < 40 && !(busy && exp_cmds.size() == 3 && (cyc - req_cyc) >= 3)) begin
      step();
      i++;
    end
    check_eq("midwait_q_level", 64'(q_level), 64'(3));
    do_reset();
    repeat (4) step();
    check_eq("midwait_no_rsp", 64'(n_rsp - base), 64'(0));

    // Randomised traffic
    rr_mode  = 2;
    gap_en   = 1'b1;
    stray_en = 1'b1;
    for (int j = 0; j < 600; j++) begin
      if (tx_q.size() < 2 && $urandom_range(0, 2) == 0) tx_q.push_back(rand_cmd());
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: APB address width.
REQ-002 Parameter DATA_WIDTH, default 32: APB data width.
REQ-003 Parameter DEPTH, default 4: command queue entries; power of 2, range 2..16.
REQ-004 Parameter TIMEOUT, default 16: maximum cycles spent waiting for apb_done.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 apb_clk  in  1  sole clock; all state changes on rising edge.
REQ-007 apb_reset  in  1  asynchronous, active-high reset.
REQ-008 cmd_valid  in  1  host command present.
REQ-009 cmd_ready  out  1  queue can accept a command.
REQ-010 cmd_wr_rd  in  1  1 = write, 0 = read.
REQ-011 cmd_addr  in  ADDR_WIDTH  target address.
REQ-012 cmd_wdata  in  DATA_WIDTH  write data; don't-care for reads.
REQ-013 apb_req  out  1  one-cycle start pulse to the APB master/slave pair.
REQ-014 apb_wr_rd, apb_addr, apb_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  current transfer; held stable from apb_req until completion.
REQ-015 apb_done  in  1  one-cycle pulse: downstream transfer complete.
REQ-016 apb_rdata  in  DATA_WIDTH  read data; valid with apb_done.
REQ-017 apb_slverr  in  1  slave error; valid with apb_done.
REQ-018 rsp_valid  out  1  response present.
REQ-019 rsp_ready  in  1  host consumes response.
REQ-020 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes, timeouts and errors.
REQ-021 rsp_err  out  1  slave error or timeout.
REQ-022 rsp_timeout  out  1  transfer aborted by timeout.
REQ-023 q_level  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-024 Queue: circular FIFO of {wr_rd, addr, wdata}; a push occurs on an edge where cmd_valid and cmd_ready are both 1.
REQ-025 cmd_ready = (q_level != DEPTH); it does not depend on a same-cycle pop, so a full queue rejects the command even when the FSM pops in that cycle.
REQ-026 Pointer wrap: read and write pointers wrap from DEPTH-1 to 0; push and pop on the same edge leave q_level unchanged.
REQ-027 FSM states are IDLE, ISSUE, WAIT and RESP.
REQ-028 IDLE: if q_level != 0, pop the head into the apb_* output registers and go to ISSUE; otherwise stay in IDLE.
REQ-029 ISSUE: apb_req = 1 for exactly this one cycle, clear the timeout counter, then go to WAIT.
REQ-030 WAIT: on apb_done, capture rsp_rdata (apb_rdata if read and !apb_slverr, else 0) and set rsp_err = apb_slverr, then go to RESP.
REQ-031 WAIT timeout: if TIMEOUT cycles elapse in WAIT without apb_done, set rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, then go to RESP.
REQ-032 RESP: rsp_valid = 1 and response fields are held stable until rsp_ready; on that handshake edge go to IDLE.
REQ-033 Latency: a command accepted into an empty queue with the FSM in IDLE produces apb_req in the cycle following the next edge, i.e. 2 edges after acceptance.
REQ-034 apb_done outside WAIT SHALL be ignored, with no state or response change.
REQ-035 Only one transfer is outstanding at a time, and responses are returned in command order.
REQ-036 apb_addr, apb_wdata and apb_wr_rd retain their last values in IDLE and RESP.

Reset
REQ-037 While apb_reset = 1: FSM = IDLE, pointers = 0, q_level = 0, cmd_ready = 0, apb_req = 0, apb_* data outputs = 0, and rsp_valid/rsp_err/rsp_timeout/rsp_rdata = 0.
REQ-038 cmd_ready rises on the first edge after reset deasserts.
REQ-039 Reset mid-operation discards queued commands, any in-flight transfer and any pending response, with no response emitted.

Structure
REQ-040 Shared package apb_cmd_pkg SHALL hold the FSM state encoding, ADDR_WIDTH/DATA_WIDTH defaults and the command-entry field layout.
REQ-041 Storage and pointers SHALL be a sub-module apb_cmd_fifo; the FSM, timeout counter and response registers stay in apb_cmd_queue.

Verification
REQ-042 Write then read: push W(0x004, 0xDEADBEEF), push R(0x004); model the slave with done 3 cycles after apb_req and rdata = 0xDEADBEEF -> two responses in order, {err 0, rdata 0}, then {err 0, rdata 0xDEADBEEF}; apb_req 2 edges after the first push.
REQ-043 Full queue: with rsp_ready = 0, push 6 commands -> cmd_ready = 0 while q_level = 4, 1 command held in RESP, the 6th stalls; with rsp_ready = 1 all 6 complete in order with pointers wrapped.
REQ-044 Slave error: read 0x3FF with apb_slverr = 1 and apb_rdata = 0x12345678 -> rsp_err 1, rsp_timeout 0, rsp_rdata 0.
REQ-045 Timeout: no apb_done after apb_req -> rsp_valid with rsp_err 1 and rsp_timeout 1 exactly TIMEOUT cycles into WAIT; a later stray apb_done is ignored.
REQ-046 Reset mid-WAIT with 3 queued commands -> all outputs 0 asynchronously, q_level 0, no response; new traffic after reset works.
REQ-047 Backpressure: hold rsp_ready low for 10 cycles -> response fields stable and no new apb_req until the handshake.
